// File: rtl/occupancy_map_updater_if.sv
// Cell-update request stream, clear control and simple dual-port map RAM port bundle.
// No logic: master is the tracer/RAM environment, slave is the updater.
// Backpressure: cell_ready from the slave qualifies cell_we from the master.
interface occupancy_map_updater_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 8,
    parameter int LOG_W = 8
);
    logic                   cell_we;
    logic                   cell_is_free;
    logic [X_W-1:0]         cell_x;
    logic [Y_W-1:0]         cell_y;
    logic                   cell_ready;
    logic                   clear_start;
    logic                   busy;
    logic [X_W+Y_W-1:0]     ram_raddr;
    logic [LOG_W-1:0]       ram_rdata;
    logic                   ram_we;
    logic [X_W+Y_W-1:0]     ram_waddr;
    logic [LOG_W-1:0]       ram_wdata;

    modport master (
        output cell_we, cell_is_free, cell_x, cell_y, clear_start, ram_rdata,
        input  cell_ready, busy, ram_raddr, ram_we, ram_waddr, ram_wdata
    );

    modport slave (
        input  cell_we, cell_is_free, cell_x, cell_y, clear_start, ram_rdata,
        output cell_ready, busy, ram_raddr, ram_we, ram_waddr, ram_wdata
    );
endinterface

// File: rtl/occupancy_map_updater.sv
// Saturating log-odds read-modify-write of occupancy cells, with forwarding and whole-map clear.
// Latency: request accepted at cycle t is written to the RAM at cycle t+2; throughput 1/cycle.
// Backpressure: cell_ready drops while draining/clearing and on the cycle clear_start is seen.
module occupancy_map_updater #(
    parameter int X_W     = 8,
    parameter int Y_W     = 8,
    parameter int LOG_W   = 8,
    parameter int L_OCC   = 9,
    parameter int L_FREE  = 3,
    parameter int LOG_MAX = 127,
    parameter int LOG_MIN = -127
) (
    input  logic                     clock,
    input  logic                     reset,
    occupancy_map_updater_if.slave   bus
);
    localparam int ADDR_W = X_W + Y_W;
    localparam logic signed [LOG_W:0] SAT_HI = (LOG_W+1)'(LOG_MAX);
    localparam logic signed [LOG_W:0] SAT_LO = (LOG_W+1)'(LOG_MIN);
    localparam logic signed [LOG_W:0] INC    = (LOG_W+1)'(L_OCC);
    localparam logic signed [LOG_W:0] DEC    = (LOG_W+1)'(-L_FREE);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_CLEAR} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic                  s1_vld_q, s1_vld_d, s1_free_q, s1_free_d;
    logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
    logic                  s2_vld_q, s2_vld_d;
    logic [ADDR_W-1:0]     s2_addr_q, s2_addr_d;
    logic [LOG_W-1:0]      s2_dat_q, s2_dat_d;
    logic                  s3_vld_q, s3_vld_d;
    logic [ADDR_W-1:0]     s3_addr_q, s3_addr_d;
    logic [LOG_W-1:0]      s3_dat_q, s3_dat_d;

    logic                  ready;
    logic                  accept;
    logic [ADDR_W-1:0]     req_addr;
    logic [LOG_W-1:0]      old_val;
    logic signed [LOG_W:0] sum;

    assign req_addr = {bus.cell_y, bus.cell_x};
    assign accept   = ready & bus.cell_we;

    // State, clear counter and pipeline registers; reset drops anything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_RUN;
            clr_cnt_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_free_q <= 1'b0;
            s1_addr_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_dat_q  <= '0;
            s3_vld_q  <= 1'b0;
            s3_addr_q <= '0;
            s3_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_free_q <= s1_free_d;
            s1_addr_q <= s1_addr_d;
            s2_vld_q  <= s2_vld_d;
            s2_addr_q <= s2_addr_d;
            s2_dat_q  <= s2_dat_d;
            s3_vld_q  <= s3_vld_d;
            s3_addr_q <= s3_addr_d;
            s3_dat_q  <= s3_dat_d;
        end
    end

    // Mode sequencing: run, wait for the pipeline to empty, sweep the whole map to zero.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        clr_cnt_d = '0;
        case (state_q)
            ST_RUN: begin
                ready = ~bus.clear_start;
                if (bus.clear_start) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!s1_vld_q && !s2_vld_q) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Datapath: forward the newest in-flight value for the cell, add and saturate.
    always_comb begin
        s1_vld_d  = accept;
        s1_free_d = bus.cell_is_free;
        s1_addr_d = req_addr;

        if (s2_vld_q && s2_addr_q == s1_addr_q)      old_val = s2_dat_q;
        else if (s3_vld_q && s3_addr_q == s1_addr_q) old_val = s3_dat_q;
        else                                         old_val = bus.ram_rdata;

        sum = $signed({old_val[LOG_W-1], old_val}) + (s1_free_q ? DEC : INC);

        s2_vld_d  = s1_vld_q;
        s2_addr_d = s1_addr_q;
        if (sum > SAT_HI)      s2_dat_d = SAT_HI[LOG_W-1:0];
        else if (sum < SAT_LO) s2_dat_d = SAT_LO[LOG_W-1:0];
        else                   s2_dat_d = sum[LOG_W-1:0];

        // The sweep rewrites every cell, so the last-written copy must not survive it.
        s3_vld_d  = s2_vld_q && !(state_q == ST_DRAIN && state_d == ST_CLEAR);
        s3_addr_d = s2_addr_q;
        s3_dat_d  = s2_dat_q;
    end

    // Port drive: RAM writes come from S2 or the clear sweep; reset forces the idle values.
    always_comb begin
        bus.cell_ready = ready;
        bus.busy       = (state_q == ST_DRAIN) || (state_q == ST_CLEAR);
        bus.ram_raddr  = accept ? req_addr : '0;
        if (state_q == ST_CLEAR) begin
            bus.ram_we    = 1'b1;
            bus.ram_waddr = clr_cnt_q;
            bus.ram_wdata = '0;
        end else begin
            bus.ram_we    = s2_vld_q;
            bus.ram_waddr = s2_addr_q;
            bus.ram_wdata = s2_dat_q;
        end
        if (reset) begin
            bus.cell_ready = 1'b1;
            bus.busy       = 1'b0;
            bus.ram_raddr  = '0;
            bus.ram_we     = 1'b0;
            bus.ram_waddr  = '0;
            bus.ram_wdata  = '0;
        end
    end
endmodule

// File: tb/tb_occupancy_map_updater.sv
// Randomized self-checking bench: a cell-level log-odds map model predicts every RAM write.
// Every expected write carries its cycle, address and value; clear sweeps are predicted too.
// A small simple dual-port RAM with read-old-data behaviour sits behind the DUT.
module tb_occupancy_map_updater;
    localparam int X_W   = 4;
    localparam int Y_W   = 4;
    localparam int LOG_W = 8;
    localparam int NCELL = 1 << (X_W + Y_W);

    typedef struct {
        int cyc;
        int addr;
        int dat;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_w = -10;
    int   ref_map [NCELL];
    wr_t  exp_q [$];

    logic                   pre_we = 1'b0;
    logic [X_W+Y_W-1:0]     pre_addr = '0;
    logic [LOG_W-1:0]       pre_dat = '0;
    logic [LOG_W-1:0]       mem [NCELL];

    occupancy_map_updater_if #(.X_W(X_W), .Y_W(Y_W), .LOG_W(LOG_W)) bus ();

    occupancy_map_updater #(.X_W(X_W), .Y_W(Y_W), .LOG_W(LOG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        bus.ram_rdata <= mem[bus.ram_raddr];
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
        if (pre_we) mem[pre_addr] <= pre_dat;
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Write monitor: every RAM write must be the next predicted one, at its predicted cycle.
    always @(negedge clock) begin
        if (bus.ram_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr_addr", int'(bus.ram_waddr), -1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", int'(bus.ram_waddr), e.addr);
                check("wr_data", int'($signed(bus.ram_wdata)), e.dat);
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            check("missing_wr_we", int'(bus.ram_we), 1);
            void'(exp_q.pop_front());
        end
    end

    function automatic int clamp(input int v);
        if (v > 127) return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    task automatic model_accept(input int x, input int y, input logic fr);
        int a;
        a = y * (1 << X_W) + x;
        ref_map[a] = clamp(ref_map[a] + (fr ? -3 : 9));
        exp_q.push_back('{cyc + 2, a, ref_map[a]});
        last_w = cyc + 2;
    endtask

    // One cycle of stimulus; entered and left just after a rising edge.
    task automatic step(input logic we, input logic fr, input int x, input int y);
        bus.cell_we      = we;
        bus.cell_is_free = fr;
        bus.cell_x       = X_W'(x);
        bus.cell_y       = Y_W'(y);
        @(negedge clock);
        if (we) begin
            check("req_ready", int'(bus.cell_ready), 1);
            model_accept(x, y, fr);
        end
        @(posedge clock); #1;
        bus.cell_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic preset(input int x, input int y, input int v);
        int a;
        a = y * (1 << X_W) + x;
        pre_we   = 1'b1;
        pre_addr = (X_W+Y_W)'(a);
        pre_dat  = LOG_W'(v);
        ref_map[a] = v;
        @(posedge clock); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_clear(input logic with_we, input int x, input int y);
        int start;
        bus.clear_start  = 1'b1;
        bus.cell_we      = with_we;
        bus.cell_is_free = 1'b0;
        bus.cell_x       = X_W'(x);
        bus.cell_y       = Y_W'(y);
        @(negedge clock);
        check("clr_cycle_ready", int'(bus.cell_ready), 0);
        start = ((cyc > last_w) ? cyc : last_w) + 2;
        for (int i = 0; i < NCELL; i++) begin
            exp_q.push_back('{start + i, i, 0});
            ref_map[i] = 0;
        end
        last_w = start + NCELL - 1;
        @(posedge clock); #1;
        bus.clear_start = 1'b0;
        bus.cell_we     = 1'b0;
        while (cyc <= last_w) begin
            @(negedge clock);
            check("clr_busy", int'(bus.busy), 1);
            check("clr_ready", int'(bus.cell_ready), 0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("post_clr_busy", int'(bus.busy), 0);
        check("post_clr_ready", int'(bus.cell_ready), 1);
        @(posedge clock); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int mism;
        bus.cell_we      = 1'b0;
        bus.cell_is_free = 1'b0;
        bus.cell_x       = '0;
        bus.cell_y       = '0;
        bus.clear_start  = 1'b0;
        for (int i = 0; i < NCELL; i++) ref_map[i] = 0;

        // Reset values.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_we", int'(bus.ram_we), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_ready", int'(bus.cell_ready), 1);
        check("rst_waddr", int'(bus.ram_waddr), 0);
        check("rst_wdata", int'(bus.ram_wdata), 0);
        check("rst_raddr", int'(bus.ram_raddr), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("run_ready", int'(bus.cell_ready), 1);
        check("run_busy", int'(bus.busy), 0);
        @(posedge clock); #1;

        // Zero the whole map.
        do_clear(1'b0, 0, 0);

        // Single update, back-to-back same cell, alternating cells.
        step(1'b1, 1'b0, 3, 5);
        idle(3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 7, 7);
        idle(3);
        step(1'b1, 1'b0, 1, 1);
        step(1'b1, 1'b0, 2, 1);
        step(1'b1, 1'b1, 1, 1);
        step(1'b1, 1'b1, 2, 1);
        idle(3);

        // Saturation at both bounds.
        preset(4, 4, 120);
        preset(5, 4, -125);
        idle(1);
        step(1'b1, 1'b0, 4, 4);
        step(1'b1, 1'b0, 4, 4);
        step(1'b1, 1'b1, 5, 4);
        step(1'b1, 1'b1, 5, 4);
        idle(3);

        // Clear with two updates in flight.
        step(1'b1, 1'b0, 9, 9);
        step(1'b1, 1'b1, 10, 9);
        do_clear(1'b0, 0, 0);

        // Reset while an update sits in S2: the write must be dropped.
        bus.cell_we = 1'b1; bus.cell_is_free = 1'b0;
        bus.cell_x = X_W'(6); bus.cell_y = Y_W'(6);
        @(posedge clock); #1;
        bus.cell_we = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("rst_drop_we", int'(bus.ram_we), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        idle(2);

        // Random traffic on a small region, with one clear raised alongside a request.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                do_clear(1'b1, 2, 2);
            end else if ($urandom_range(0, 9) < 8) begin
                step(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)));
            end else begin
                idle(1);
            end
        end
        idle(4);

        check("pending_writes", exp_q.size(), 0);
        mism = 0;
        for (int i = 0; i < NCELL; i++)
            if (int'($signed(mem[i])) !== ref_map[i]) mism++;
        check("map_contents_mismatches", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
